// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store request and response bundle between core and data memory
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with wait states and byte-lane merge
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_commit;
    logic          w_sel_in;
    logic          w_we;
    logic [1:0]    w_size;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic          w_err;
    logic [3:0]    w_be;
    logic [31:0]   w_lane_data;
    logic [31:0]   w_rdata;
    logic [AW-1:0] w_idx;
    logic          w_unused;

    assign bus.req_ready = rst_n && (r_state == S_IDLE);
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_unused      = bus.req_funct3[2];

    // With zero wait states the commit happens on the acceptance edge, so
    // the datapath must see the live request rather than the latched copy.
    assign w_sel_in = (r_state == S_IDLE);
    assign w_we     = w_sel_in ? bus.req_we         : r_we;
    assign w_size   = w_sel_in ? bus.req_funct3[1:0] : r_size;
    assign w_addr   = w_sel_in ? bus.req_addr       : r_addr;
    assign w_wdata  = w_sel_in ? bus.req_wdata      : r_wdata;
    assign w_idx    = w_addr[AW+1:2];

    assign w_err = (w_size == 2'b11)
                || (w_size == 2'b01 && w_addr[0])
                || (w_size == 2'b10 && w_addr[1:0] != 2'b00)
                || ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));

    always_comb begin
        w_be        = 4'b1111;
        w_lane_data = w_wdata;
        case (w_size)
            2'b00: begin
                w_be        = 4'b0001 << w_addr[1:0];
                w_lane_data = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = w_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{w_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_lane_data = w_wdata;
            end
        endcase
    end

    assign w_rdata = r_mem[w_idx] >> {w_addr[1:0], 3'b000};

    always_comb begin
        w_next   = r_state;
        w_commit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 0) begin
                        w_commit = 1'b1;
                        w_next   = S_RESP;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_commit = 1'b1;
                    w_next   = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_size  <= bus.req_funct3[1:0];
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_cnt   <= 4'(LATENCY);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_resp_valid <= w_commit;
            if (w_commit) begin
                r_resp_err   <= w_err;
                r_resp_rdata <= (w_err || w_we) ? 32'd0 : w_rdata;
            end
        end
    end

    // Storage is deliberately not reset; the write is gated by rst_n so a
    // reset landing on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && w_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
                end
            end
        end
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
endmodule
